aes_inv_key_stepper: RTL and testbench

- Iterative AES-128 key schedule that runs in the decryption direction.
- Takes the round-10 key and walks the schedule backwards, one round per accepted output. Round keys stream out in decryption order: 10, 9, …, 0.
- Feeds the iterative inverse-cipher datapath through a valid/ready handshake.
- Uses 4 shared sbox instances instead of 40 parallel ones. Trades latency for area against the fully unrolled combinational expander.

---
 rtl/aes_inv_key_stepper_if.sv | 36 +++
 rtl/aes_inv_key_stepper.sv | 186 ++++++++++++++++++
 tb/tb_aes_inv_key_stepper.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_stepper_if.sv
// Handshake bundle between the AES-128 inverse key stepper and its consumer.
// The slave modport is the stepper; the master modport is the key consumer.
interface aes_inv_key_stepper_if #(
  parameter int IDXW = 4
) ();
  logic            load;
  logic [127:0]    key_in;
  logic            key_ready;
  logic [127:0]    round_key;
  logic [IDXW-1:0] round_idx;
  logic            key_valid;
  logic            busy;
  logic            done;

  modport slave (
    input  load,
    input  key_in,
    input  key_ready,
    output round_key,
    output round_idx,
    output key_valid,
    output busy,
    output done
  );

  modport master (
    output load,
    output key_in,
    output key_ready,
    input  round_key,
    input  round_idx,
    input  key_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/aes_inv_key_stepper.sv
// Iterative AES-128 key schedule that streams round keys 10..0 over valid/ready.
// Optional macro FWD_PRECOMPUTE_EN: accept the cipher key and expand forward first.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    logic [7:0] yy;
    p  = 8'h00;
    xx = x;
    yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) p = p ^ xx;
      xx = xx[7] ? ({xx[6:0], 1'b0} ^ 8'h1b) : {xx[6:0], 1'b0};
      yy = {1'b0, yy[7:1]};
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // Multiplicative inverse as a^254 (254 = 2+4+...+128); maps 0 to 0 as required.
  always_comb begin
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_stepper #(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_key_stepper_if.slave  kif
);
`ifdef FWD_PRECOMPUTE_EN
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t          state_reg;
  logic [127:0]    key_reg;
  logic [IDXW-1:0] idx_reg;
  logic            valid_reg;
  logic            busy_reg;
  logic            done_reg;
`ifdef FWD_PRECOMPUTE_EN
  logic [IDXW-1:0] cnt_reg;
  logic [127:0]    fwd_next;
`endif

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sb_word;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [127:0] prev_next;

  function automatic logic [7:0] rcon(input logic [IDXW-1:0] r);
    case (int'(r))
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    k0 = key_reg[127:96];
    k1 = key_reg[95:64];
    k2 = key_reg[63:32];
    k3 = key_reg[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
`ifdef FWD_PRECOMPUTE_EN
    // Forward expansion and backward stepping share one SubWord datapath.
    sb_word = (state_reg == EXPAND) ? k3 : p3;
`else
    sb_word = p3;
`endif
    rot_word  = {sb_word[23:0], sb_word[31:24]};
    prev_next = {k0 ^ sub_word ^ {rcon(idx_reg), 24'h000000}, p1, p2, p3};
`ifdef FWD_PRECOMPUTE_EN
    fwd_next[127:96] = k0 ^ sub_word ^ {rcon(cnt_reg), 24'h000000};
    fwd_next[95:64]  = k1 ^ fwd_next[127:96];
    fwd_next[63:32]  = k2 ^ fwd_next[95:64];
    fwd_next[31:0]   = k3 ^ fwd_next[63:32];
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .a (rot_word[gi*8 +: 8]),
        .s (sub_word[gi*8 +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef FWD_PRECOMPUTE_EN
      cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (kif.load) begin
            key_reg  <= kif.key_in;
            idx_reg  <= IDXW'(NR);
            busy_reg <= 1'b1;
`ifdef FWD_PRECOMPUTE_EN
            cnt_reg   <= IDXW'(1);
            state_reg <= EXPAND;
`else
            valid_reg <= 1'b1;
            state_reg <= EMIT;
`endif
          end
        end
`ifdef FWD_PRECOMPUTE_EN
        EXPAND: begin
          key_reg <= fwd_next;
          if (cnt_reg == IDXW'(NR)) begin
            valid_reg <= 1'b1;
            state_reg <= EMIT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        EMIT: begin
          if (kif.key_ready) begin
            if (idx_reg == '0) begin
              // Round-0 key stays on round_key after the stream ends.
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              key_reg <= prev_next;
              idx_reg <= idx_reg - 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign kif.round_key = key_reg;
  assign kif.round_idx = idx_reg;
  assign kif.key_valid = valid_reg;
  assign kif.busy      = busy_reg;
  assign kif.done      = done_reg;
endmodule

// File: tb/tb_aes_inv_key_stepper.sv
// Scoreboard bench for aes_inv_key_stepper using the FIPS-197 key schedule.
module tb_aes_inv_key_stepper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_key_stepper_if #(.IDXW(4)) kif ();
  aes_inv_key_stepper #(.NR(10), .IDXW(4)) dut (.clk(clk), .rst(rst), .kif(kif));

`ifdef FWD_PRECOMPUTE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] rk [0:10];
  logic [127:0] zk10;
  logic [127:0] zk1;
  int           checks = 0;
  int           failures = 0;
  int           valid_cnt = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (kif.key_valid) valid_cnt++;
    if (kif.done) done_cnt++;
    if (kif.key_valid && kif.key_ready && !rst) begin
      checks++;
      $display("txn idx=%0d key=%h", kif.round_idx, kif.round_key);
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got idx=%0d key=%h want no transaction", kif.round_idx, kif.round_key);
      end else begin
        mon_e = sb.pop_front();
        if (kif.round_idx !== mon_e.idx || (mon_e.chk && kif.round_key !== mon_e.key)) begin
          failures++;
          $display("FAIL sb_key got idx=%0d key=%h want idx=%0d key=%h",
                   kif.round_idx, kif.round_key, mon_e.idx, mon_e.key);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] a_load();
`ifdef FWD_PRECOMPUTE_EN
    return rk[0];
`else
    return rk[10];
`endif
  endfunction

  function automatic logic [127:0] z_load();
`ifdef FWD_PRECOMPUTE_EN
    return 128'h0;
`else
    return zk10;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int lo);
    for (int r = 10; r >= lo; r--) sb.push_back('{idx: 4'(r), key: rk[r], chk: 1'b1});
  endtask

  task automatic push_z();
    for (int r = 10; r >= 0; r--) begin
      if (r == 10)     sb.push_back('{idx: 4'(r), key: zk10, chk: 1'b1});
      else if (r == 1) sb.push_back('{idx: 4'(r), key: zk1, chk: 1'b1});
      else if (r == 0) sb.push_back('{idx: 4'(r), key: 128'h0, chk: 1'b1});
      else             sb.push_back('{idx: 4'(r), key: 128'h0, chk: 1'b0});
    end
  endtask

  task automatic start(input logic [127:0] k);
    kif.key_in = k;
    kif.load   = 1'b1;
    tick();
    kif.load   = 1'b0;
  endtask

  task automatic run_until_idx(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (kif.key_valid && int'(kif.round_idx) == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_until_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (kif.done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    kif.load = 1'b0;
    kif.key_ready = 1'b1;
    kif.key_in = '0;
    tick();
    tick();
    checks++;
    if (kif.key_valid !== 1'b0 || kif.busy !== 1'b0 || kif.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b busy=%b done=%b want 0 0 0", kif.key_valid, kif.busy, kif.done);
    end
    checks++;
    if (kif.round_key !== 128'h0 || kif.round_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_data got key=%h idx=%0d want 0 0", kif.round_key, kif.round_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    valid_cnt = 0;
    done_cnt = 0;
    push_a(0);
    start(a_load());
    for (int c = 1; c < LAT; c++) begin
      checks++;
      if (kif.key_valid !== 1'b0 || kif.busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_expand cyc=%0d got valid=%b busy=%b want 0 1", c, kif.key_valid, kif.busy);
      end
      tick();
    end
    checks++;
    if (kif.key_valid !== 1'b1 || kif.round_idx !== 4'd10 || kif.round_key !== rk[10] || kif.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_first got valid=%b idx=%0d key=%h want 1 10 %h", kif.key_valid, kif.round_idx, kif.round_key, rk[10]);
    end
    run_until_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_done_timeout got no done want done");
    end
    checks++;
    if (kif.key_valid !== 1'b0 || kif.busy !== 1'b0 || kif.round_key !== rk[0] || kif.round_idx !== 4'd0) begin
      failures++;
      $display("FAIL basic_end got valid=%b busy=%b key=%h idx=%0d want 0 0 %h 0",
               kif.key_valid, kif.busy, kif.round_key, kif.round_idx, rk[0]);
    end
    tick();
    checks++;
    if (kif.done !== 1'b0 || done_cnt != 1 || valid_cnt != 11 || sb.size() != 0) begin
      failures++;
      $display("FAIL basic_counts got done=%b pulses=%0d valid_cycles=%0d left=%0d want 0 1 11 0",
               kif.done, done_cnt, valid_cnt, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    push_a(0);
    start(a_load());
    run_until_idx(7, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_reach7 got timeout want idx 7");
    end
    kif.key_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (kif.key_valid !== 1'b1 || kif.round_idx !== 4'd7 || kif.round_key !== rk[7]) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got valid=%b idx=%0d key=%h want 1 7 %h",
                 c, kif.key_valid, kif.round_idx, kif.round_key, rk[7]);
      end
    end
    kif.key_ready = 1'b1;
    run_until_done(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL bp_finish got done=%b left=%0d want 1 0", ok, sb.size());
    end
    tick();
  endtask

  task automatic test_busy_load();
    bit ok;
    push_a(0);
    start(a_load());
    run_until_idx(5, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL busy_reach5 got timeout want idx 5");
    end
    kif.key_in = zk10;
    kif.load = 1'b1;
    tick();
    kif.load = 1'b0;
    checks++;
    if (kif.round_idx !== 4'd4 || kif.round_key !== rk[4] || kif.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore got idx=%0d key=%h busy=%b want 4 %h 1", kif.round_idx, kif.round_key, kif.busy, rk[4]);
    end
    run_until_done(ok);
    tick();
    checks++;
    if (!ok || sb.size() != 0 || kif.key_valid !== 1'b0 || kif.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_finish got done=%b left=%0d valid=%b busy=%b want 1 0 0 0", ok, sb.size(), kif.key_valid, kif.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_a(5);
    start(a_load());
    run_until_idx(4, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_reach4 got timeout want idx 4");
    end
    kif.key_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    kif.key_ready = 1'b1;
    checks++;
    if (kif.key_valid !== 1'b0 || kif.busy !== 1'b0 || kif.done !== 1'b0 ||
        kif.round_key !== 128'h0 || kif.round_idx !== 4'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL rstmid_state got valid=%b busy=%b done=%b key=%h idx=%0d left=%0d want 0 0 0 0 0 0",
               kif.key_valid, kif.busy, kif.done, kif.round_key, kif.round_idx, sb.size());
    end
    push_a(0);
    start(a_load());
    run_until_idx(10, ok);
    checks++;
    if (!ok || kif.round_key !== rk[10]) begin
      failures++;
      $display("FAIL rstmid_restart got ok=%b key=%h want 1 %h", ok, kif.round_key, rk[10]);
    end
    run_until_done(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL rstmid_finish got done=%b left=%0d want 1 0", ok, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    tick();
    push_a(0);
    start(a_load());
    run_until_done(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_first got done=%b left=%0d want 1 0", ok, sb.size());
    end
    push_z();
    start(z_load());
    for (int c = 1; c < LAT; c++) begin
      checks++;
      if (kif.key_valid !== 1'b0 || kif.busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_expand cyc=%0d got valid=%b busy=%b want 0 1", c, kif.key_valid, kif.busy);
      end
      tick();
    end
    checks++;
    if (kif.key_valid !== 1'b1 || kif.round_idx !== 4'd10 || kif.round_key !== zk10) begin
      failures++;
      $display("FAIL b2b_start got valid=%b idx=%0d key=%h want 1 10 %h", kif.key_valid, kif.round_idx, kif.round_key, zk10);
    end
    run_until_done(ok);
    checks++;
    if (!ok || sb.size() != 0 || kif.round_key !== 128'h0) begin
      failures++;
      $display("FAIL b2b_second got done=%b left=%0d key=%h want 1 0 0", ok, sb.size(), kif.round_key);
    end
    tick();
  endtask

  initial begin
    kif.load = 1'b0;
    kif.key_ready = 1'b1;
    kif.key_in = '0;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    zk1    = 128'h62636363626363636263636362636363;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_load();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
